// File: rtl/fire_pkg.sv
// rtl/fire_pkg.sv - shared defaults and state type for the fire6 squeeze OFM writer
package fire_pkg;

  localparam int FIRE_WIDTH  = 16;
  localparam int FIRE_DSP_NO = 64;
  localparam int FIRE_WOUT   = 16;
  localparam int FIRE_ADDR_W = 14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } ofm_state_t;

endpackage

// File: rtl/ofm_serializer.sv
// rtl/ofm_serializer.sv - shadow bank that captures a pixel vector and muxes out one channel word
module ofm_serializer #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 64,
  parameter int IDX_W  = $clog2(DSP_NO)
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] vector [0:DSP_NO-1],
  input  logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] word
);

  // Not reset: contents are only meaningful after a load.
  logic [WIDTH-1:0] shadow [0:DSP_NO-1];

  always_ff @(posedge clk) begin
    if (load) shadow <= vector;
  end

  assign word = shadow[index];

endmodule

// File: rtl/fire6_squeeze_ofm_writer.sv
// rtl/fire6_squeeze_ofm_writer.sv - serialises squeeze-layer pixel vectors into a channel-major RAM image
module fire6_squeeze_ofm_writer
  import fire_pkg::*;
#(
  parameter int WIDTH  = FIRE_WIDTH,
  parameter int DSP_NO = FIRE_DSP_NO,
  parameter int WOUT   = FIRE_WOUT,
  parameter int ADDR_W = FIRE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_i,
  input  logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1],
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [WIDTH-1:0]  ram_data_o,
  output logic              ram_feedback_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int PIX_N = WOUT * WOUT;
  localparam int CH_W  = $clog2(DSP_NO);
  localparam int PIX_W = $clog2(PIX_N);

  ofm_state_t       state, state_nx;
  logic [CH_W-1:0]  chan;
  logic [PIX_W-1:0] pix;
  logic             load;
  logic             last_ch;
  logic             last_pix;
  logic             feedback_q, done_q, overflow_q;

  assign last_ch  = (chan == CH_W'(DSP_NO - 1));
  assign last_pix = (pix == PIX_W'(PIX_N - 1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_i) begin
          load     = 1'b1;
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_ch) state_nx = last_pix ? S_DONE : S_IDLE;
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      chan       <= '0;
      pix        <= '0;
      feedback_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nx;
      feedback_q <= (state == S_DRAIN) && (state_nx == S_DONE);
      if ((state == S_DRAIN) && (state_nx == S_DONE)) done_q <= 1'b1;
      if (state == S_DRAIN) begin
        chan <= last_ch ? '0 : chan + CH_W'(1);
        // pix saturates on the last pixel so the address never leaves the map
        if (last_ch && !last_pix) pix <= pix + PIX_W'(1);
        if (sample_i) overflow_q <= 1'b1;
      end
    end
  end

  ofm_serializer #(
    .WIDTH  (WIDTH),
    .DSP_NO (DSP_NO),
    .IDX_W  (CH_W)
  ) u_serializer (
    .clk    (clk),
    .load   (load),
    .vector (ofm_i),
    .index  (chan),
    .word   (ram_data_o)
  );

  assign ram_we_o       = (state == S_DRAIN);
  assign busy_o         = (state == S_DRAIN);
  assign ram_addr_o     = ADDR_W'(chan) * ADDR_W'(PIX_N) + ADDR_W'(pix);
  assign ram_feedback_o = feedback_q;
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fire6_squeeze_ofm_writer.sv
// tb/tb_fire6_squeeze_ofm_writer.sv - self-checking bench for fire6_squeeze_ofm_writer
module tb_fire6_squeeze_ofm_writer;

  localparam int W    = 16;
  localparam int N    = 64;
  localparam int WO   = 16;
  localparam int AW   = 14;
  localparam int PIXN = WO * WO;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_i;
  logic [W-1:0]  ofm_i [0:N-1];
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [W-1:0]  ram_data_o;
  logic          ram_feedback_o, busy_o, done_o, overflow_o;

  fire6_squeeze_ofm_writer #(
    .WIDTH(W), .DSP_NO(N), .WOUT(WO), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .ofm_i(ofm_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_feedback_o(ram_feedback_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  fb_cnt = 0;
  int  fb_cyc = -1;

  always @(negedge clk) begin
    if (ram_we_o === 1'b1) obs_q.push_back('{int'(ram_addr_o), int'(ram_data_o), cyc});
    if (ram_feedback_o === 1'b1) begin
      fb_cnt = fb_cnt + 1;
      fb_cyc = cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one accepted sample = one pixel of DSP_NO channel-major writes
  int       m_pix;
  int       m_last_wr;
  bit       m_over;
  bit       m_done;
  int       m_fb_cnt;
  int       m_fb_cyc;
  logic [W-1:0] vec_buf [0:N-1];

  function automatic void model_reset(input int cutoff);
    wr_t keep[$];
    foreach (exp_q[i]) if (exp_q[i].cyc < cutoff) keep.push_back(exp_q[i]);
    exp_q     = keep;
    m_pix     = 0;
    m_last_wr = -1000;
    m_over    = 1'b0;
    m_done    = 1'b0;
    m_fb_cnt  = 0;
    m_fb_cyc  = -1;
  endfunction

  // k is the cycle index right after the capturing edge; sample_i was high during cycle k-1
  function automatic void model_sample(input int k);
    if (m_done) return;
    if (k - 1 <= m_last_wr) begin
      m_over = 1'b1;
      return;
    end
    for (int c = 0; c < N; c++)
      exp_q.push_back('{c * PIXN + m_pix, int'(vec_buf[c]), k + c});
    m_last_wr = k + N - 1;
    if (m_pix == PIXN - 1) begin
      m_done   = 1'b1;
      m_fb_cnt = m_fb_cnt + 1;
      m_fb_cyc = k + N;
    end else begin
      m_pix = m_pix + 1;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_vec();
    for (int c = 0; c < N; c++) vec_buf[c] = W'($urandom);
  endtask

  task automatic send();
    @(negedge clk);
    for (int c = 0; c < N; c++) ofm_i[c] = vec_buf[c];
    sample_i = 1'b1;
    @(negedge clk);
    sample_i = 1'b0;
    for (int c = 0; c < N; c++) ofm_i[c] = W'($urandom);
    model_sample(cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(cyc);
    fb_cnt = 0;
    fb_cyc = -1;
  endtask

  task automatic check_writes(input string name);
    int n;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].cyc !== exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                 name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string name);
    n_checks++;
    if (busy_o !== 1'b0 || overflow_o !== m_over || done_o !== m_done) begin
      n_fail++;
      $display("FAIL %s flags: got busy=%b ovf=%b done=%b expected busy=0 ovf=%b done=%b",
               name, busy_o, overflow_o, done_o, m_over, m_done);
    end
    n_checks++;
    if (fb_cnt !== m_fb_cnt || fb_cyc !== m_fb_cyc) begin
      n_fail++;
      $display("FAIL %s feedback: got count=%0d cyc=%0d expected count=%0d cyc=%0d",
               name, fb_cnt, fb_cyc, m_fb_cnt, m_fb_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_i = 1'b0;
    for (int c = 0; c < N; c++) ofm_i[c] = '0;
    idle(3);
    rst = 1'b0;
    model_reset(cyc);
    obs_q.delete();
    fb_cnt = 0;
    fb_cyc = -1;
    idle(1);
    n_checks++;
    if (ram_we_o !== 1'b0 || ram_feedback_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got we=%b fb=%b expected 0 0", ram_we_o, ram_feedback_o);
    end
    check_flags("reset");
  endtask

  task automatic test_single_vector();
    for (int c = 0; c < N; c++) vec_buf[c] = W'(c + 'h100);
    send();
    idle(N + 4);
    check_writes("single_vector");
    check_flags("single_vector");
  endtask

  task automatic test_overflow();
    do_reset();
    rand_vec();
    send();
    idle(8);
    rand_vec();
    send();
    idle(N + 4);
    check_writes("overflow");
    check_flags("overflow");
    rand_vec();
    send();
    idle(N + 4);
    check_writes("overflow_next_pix1");
  endtask

  task automatic test_boundary();
    do_reset();
    rand_vec();
    send();
    idle(N - 2);
    rand_vec();
    send();
    n_checks++;
    if (overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary overflow: got %b expected 1", overflow_o);
    end
    rand_vec();
    send();
    idle(N + 4);
    check_writes("boundary");
    check_flags("boundary");
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    rand_vec();
    send();
    idle(19);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(cyc);
    n_checks++;
    if (ram_we_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drain we: got we=%b busy=%b expected 0 0", ram_we_o, busy_o);
    end
    idle(3);
    rand_vec();
    send();
    idle(N + 4);
    check_writes("reset_mid_drain");
    check_flags("reset_mid_drain");
  endtask

  task automatic test_full_layer();
    int last_addr;
    do_reset();
    for (int p = 0; p < PIXN; p++) begin
      rand_vec();
      send();
      idle($urandom_range(N - 1, N + 2));
    end
    idle(8);
    last_addr = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].addr : -1;
    n_checks++;
    if (last_addr !== 'h3FFF) begin
      n_fail++;
      $display("FAIL full_layer last_addr: got %0h expected 3fff", last_addr);
    end
    check_writes("full_layer");
    check_flags("full_layer");
  endtask

  task automatic test_post_done();
    rand_vec();
    send();
    idle(N + 4);
    check_writes("post_done");
    check_flags("post_done");
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_overflow();
    test_boundary();
    test_reset_mid_drain();
    test_full_layer();
    test_post_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fire6_squeeze_ofm_writer.md
FIRE6_SQUEEZE_OFM_WRITER -- requirements
Module: fire6_squeeze_ofm_writer

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning):
- WIDTH, 16, fixed-point word width.
- DSP_NO, 64, number of parallel output channels.
- WOUT, 16, output feature-map side length, giving 256 pixels.
- ADDR_W, 14, RAM address width, equal to clog2(DSP_NO*WOUT*WOUT).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic is on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- sample_i, in, 1, one-cycle pulse: ofm_i holds a valid pixel vector this cycle.
- ofm_i, in, WIDTH x DSP_NO (unpacked array [0:DSP_NO-1]), post-ReLU squeeze outputs.
- ram_we_o, out, 1, RAM write enable.
- ram_addr_o, out, ADDR_W, RAM write address.
- ram_data_o, out, WIDTH, RAM write data.
- ram_feedback_o, out, 1, one-cycle pulse when the full feature map is stored.
- busy_o, out, 1, high while draining a captured vector.
- done_o, out, 1, high and held once all WOUT*WOUT pixels are written.
- overflow_o, out, 1, sticky flag: a sample arrived while busy.

Function
REQ-003 The block SHALL implement the states IDLE, DRAIN and DONE.
REQ-004 In IDLE, sample_i=1 SHALL copy all DSP_NO words of ofm_i into a shadow register bank and move to DRAIN on the same edge.
REQ-005 In DRAIN, the block SHALL write one word per cycle, channel c = 0..DSP_NO-1 in ascending order; the write of channel c SHALL occur c+1 cycles after the capturing edge.
REQ-006 Write address SHALL be c*WOUT*WOUT + pix, where pix is the current pixel counter (channel-major layout); ram_data_o SHALL equal shadow[c].
REQ-007 ram_we_o SHALL be high only on DRAIN cycles; in other states ram_addr_o and ram_data_o are don't-care.
REQ-008 After the channel DSP_NO-1 write, pix SHALL increment by 1. The next state SHALL be DONE if pix was WOUT*WOUT-1, else IDLE.
REQ-009 On entry to DONE, ram_feedback_o SHALL pulse high for exactly one cycle; done_o SHALL be high from that cycle and held until reset.
REQ-010 sample_i during DRAIN SHALL be ignored (shadow bank unchanged) and SHALL set overflow_o, which stays high until reset.
REQ-011 sample_i during DONE SHALL be ignored and SHALL NOT set overflow_o.
REQ-012 A sample_i arriving on the same cycle as the final channel write SHALL count as arriving during DRAIN (overflow).
REQ-013 busy_o SHALL equal (state == DRAIN).
REQ-014 The channel counter SHALL wrap to 0 after DSP_NO-1; pix SHALL never exceed WOUT*WOUT-1.
REQ-015 Address arithmetic SHALL be unsigned and ADDR_W bits wide, with no truncation for the default parameters.

Reset
REQ-016 rst=1 at a rising edge SHALL force IDLE and clear pix, the channel counter, ram_we_o, ram_feedback_o, busy_o, done_o and overflow_o to 0; the shadow bank is not reset.
REQ-017 Reset asserted mid-DRAIN SHALL abort the drain with no further writes; the first sample after reset SHALL be written as pix 0.
REQ-018 No initial blocks SHALL be relied on for functional state.

Structure
REQ-019 WIDTH, DSP_NO, WOUT, ADDR_W defaults and the state enum type SHALL live in shared package fire_pkg.
REQ-020 The shadow bank plus channel mux SHALL be a sub-module, ofm_serializer (inputs load, vector, index; output word).
REQ-021 Total RTL SHALL be single-clock, with no latches and no combinational path from sample_i to ram_we_o.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single vector: after reset, sample with ofm_i[c]=c+0x100 -> 64 writes, addr = c*256, data = 0x100+c, then busy_o=0 and state IDLE.
- Full layer: 256 samples spaced 2304 cycles -> 16384 writes; pixel 255, channel 63 lands at addr 0x3FFF; ram_feedback_o pulses once; done_o=1; overflow_o=0.
- Overflow: sample, then a second sample 10 cycles later -> overflow_o=1; the 64 writes carry the first vector's data; pix=1 afterwards.
- Boundary: second sample on the final-write cycle -> overflow_o=1; the next sample after IDLE is written at pix 1.
- Reset mid-drain: rst at channel 20 -> ram_we_o=0 next cycle; a new sample writes addr 0..(63*256) with pix 0.
- Post-done: sample while done_o=1 -> no writes, overflow_o stays 0.
